// File: rtl/memory_access_stage.sv
// Pipeline memory stage: issues one data-memory request per aligned load/store, aligns and
// extends load data, and registers the write-back fields while stalling upstream during an access.
module memory_access_stage #(
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADD_WIDTH    = 5,
  parameter int unsigned D_CACHE_LW_WIDTH = 3,
  parameter int unsigned D_CACHE_SW_WIDTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
  input  logic [DATA_WIDTH-1:0]       ALU_OUT_IN,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
  input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
  input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA,
  input  logic                        WRITE_BACK_MUX_SELECT_IN,
  input  logic                        RD_WRITE_ENABLE_IN,
  output logic                        STALL_MEMORY_STAGE,
  output logic                        MEM_REQ_VALID,
  input  logic                        MEM_REQ_READY,
  output logic                        MEM_WE,
  output logic [DATA_WIDTH/8-1:0]     MEM_BYTE_EN,
  output logic [ADDRESS_WIDTH-1:0]    MEM_ADDR,
  output logic [DATA_WIDTH-1:0]       MEM_WDATA,
  input  logic                        MEM_RESP_VALID,
  input  logic [DATA_WIDTH-1:0]       MEM_RDATA,
  output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
  output logic [DATA_WIDTH-1:0]       ALU_OUT,
  output logic [DATA_WIDTH-1:0]       LOAD_DATA_OUT,
  output logic                        WRITE_BACK_MUX_SELECT_OUT,
  output logic                        RD_WRITE_ENABLE_OUT,
  output logic                        MISALIGNED_ERROR
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  localparam logic [D_CACHE_LW_WIDTH-1:0] LdNone = D_CACHE_LW_WIDTH'(0);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LdB    = D_CACHE_LW_WIDTH'(1);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LdH    = D_CACHE_LW_WIDTH'(2);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LdW    = D_CACHE_LW_WIDTH'(3);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LdBu   = D_CACHE_LW_WIDTH'(4);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LdHu   = D_CACHE_LW_WIDTH'(5);

  localparam logic [D_CACHE_SW_WIDTH-1:0] StNone = D_CACHE_SW_WIDTH'(0);
  localparam logic [D_CACHE_SW_WIDTH-1:0] StB    = D_CACHE_SW_WIDTH'(1);
  localparam logic [D_CACHE_SW_WIDTH-1:0] StH    = D_CACHE_SW_WIDTH'(2);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                      state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic                        we_q, we_d;
  logic [BeWidth-1:0]          be_q, be_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [D_CACHE_LW_WIDTH-1:0] lcode_q, lcode_d;
  logic [1:0]                  off_q, off_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;

  logic [REG_ADD_WIDTH-1:0]    rd_q, rd_d;
  logic [DATA_WIDTH-1:0]       alu_q, alu_d;
  logic [DATA_WIDTH-1:0]       load_data_q, load_data_d;
  logic                        wb_sel_q, wb_sel_d;
  logic                        rd_we_q, rd_we_d;
  logic                        mis_q, mis_d;

  logic                        is_load, is_store, is_half, is_word, misaligned, access;
  logic [1:0]                  in_off;
  logic [BeWidth-1:0]          in_be;
  logic [DATA_WIDTH-1:0]       in_wdata;
  logic [DATA_WIDTH-1:0]       shifted, load_ext;

  // Instruction decode; a load code outranks a simultaneous store code.
  always_comb begin
    in_off   = ALU_OUT_IN[1:0];
    is_load  = (DATA_CACHE_LOAD_IN >= LdB) && (DATA_CACHE_LOAD_IN <= LdHu);
    is_store = !is_load && (DATA_CACHE_STORE_IN != StNone);
    is_half  = (is_load && (DATA_CACHE_LOAD_IN == LdH || DATA_CACHE_LOAD_IN == LdHu)) ||
               (is_store && DATA_CACHE_STORE_IN == StH);
    is_word  = (is_load && DATA_CACHE_LOAD_IN == LdW) ||
               (is_store && DATA_CACHE_STORE_IN == D_CACHE_SW_WIDTH'(3));
    misaligned = (is_half && in_off[0]) || (is_word && (in_off != 2'b00));
    access     = (is_load || is_store) && !misaligned;

    in_be    = {BeWidth{1'b1}};
    in_wdata = DATA_CACHE_STORE_DATA;
    if (is_store) begin
      if (DATA_CACHE_STORE_IN == StB) begin
        in_be    = BeWidth'(1) << in_off;
        in_wdata = {BeWidth{DATA_CACHE_STORE_DATA[7:0]}};
      end else if (DATA_CACHE_STORE_IN == StH) begin
        in_be    = in_off[1] ? BeWidth'(4'b1100) : BeWidth'(4'b0011);
        in_wdata = {(BeWidth / 2){DATA_CACHE_STORE_DATA[15:0]}};
      end
    end
  end

  // Align the captured word to the addressed byte, then extend per load type.
  always_comb begin
    shifted = rdata_q >> {off_q, 3'b000};
    unique case (lcode_q)
      LdB:     load_ext = {{(DATA_WIDTH - 8){shifted[7]}}, shifted[7:0]};
      LdH:     load_ext = {{(DATA_WIDTH - 16){shifted[15]}}, shifted[15:0]};
      LdBu:    load_ext = {{(DATA_WIDTH - 8){1'b0}}, shifted[7:0]};
      LdHu:    load_ext = {{(DATA_WIDTH - 16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    lcode_d     = lcode_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    load_data_d = load_data_q;
    wb_sel_d    = wb_sel_q;
    rd_we_d     = rd_we_q;
    mis_d       = mis_q;
    STALL_MEMORY_STAGE = 1'b0;
    MEM_REQ_VALID      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          STALL_MEMORY_STAGE = 1'b1;
          state_d = StReq;
          addr_d  = {ALU_OUT_IN[ADDRESS_WIDTH-1:2], 2'b00};
          we_d    = is_store;
          be_d    = in_be;
          wdata_d = in_wdata;
          lcode_d = is_load ? DATA_CACHE_LOAD_IN : LdNone;
          off_d   = in_off;
          // Bubble to write-back while stalled: no register write, no error pulse.
          rd_we_d = 1'b0;
          mis_d   = 1'b0;
        end else begin
          rd_d        = RD_ADDRESS_IN;
          alu_d       = ALU_OUT_IN;
          load_data_d = '0;
          wb_sel_d    = WRITE_BACK_MUX_SELECT_IN;
          rd_we_d     = RD_WRITE_ENABLE_IN && !misaligned;
          mis_d       = misaligned;
        end
      end
      StReq: begin
        STALL_MEMORY_STAGE = 1'b1;
        MEM_REQ_VALID      = 1'b1;
        rd_we_d = 1'b0;
        mis_d   = 1'b0;
        if (MEM_REQ_READY) begin
          state_d = we_q ? StDone : StWait;
        end
      end
      StWait: begin
        STALL_MEMORY_STAGE = 1'b1;
        rd_we_d = 1'b0;
        mis_d   = 1'b0;
        if (MEM_RESP_VALID) begin
          rdata_d = MEM_RDATA;
          state_d = StDone;
        end
      end
      StDone: begin
        // Upstream still holds this instruction on the inputs during this cycle.
        state_d     = StIdle;
        rd_d        = RD_ADDRESS_IN;
        alu_d       = ALU_OUT_IN;
        wb_sel_d    = WRITE_BACK_MUX_SELECT_IN;
        load_data_d = we_q ? '0 : load_ext;
        rd_we_d     = we_q ? 1'b0 : RD_WRITE_ENABLE_IN;
        mis_d       = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      lcode_q     <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      load_data_q <= '0;
      wb_sel_q    <= 1'b0;
      rd_we_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      lcode_q     <= lcode_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      load_data_q <= load_data_d;
      wb_sel_q    <= wb_sel_d;
      rd_we_q     <= rd_we_d;
      mis_q       <= mis_d;
    end
  end

  assign MEM_WE                    = we_q;
  assign MEM_BYTE_EN               = be_q;
  assign MEM_ADDR                  = addr_q;
  assign MEM_WDATA                 = wdata_q;
  assign RD_ADDRESS_OUT            = rd_q;
  assign ALU_OUT                   = alu_q;
  assign LOAD_DATA_OUT             = load_data_q;
  assign WRITE_BACK_MUX_SELECT_OUT = wb_sel_q;
  assign RD_WRITE_ENABLE_OUT       = rd_we_q;
  assign MISALIGNED_ERROR          = mis_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage: a memory responder with variable ready/response delay
// and a reference model that derives expected requests and write-back fields from the access rules.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_in;
  logic [31:0] alu_in;
  logic [2:0]  ld_in;
  logic [1:0]  st_in;
  logic [31:0] sdata_in;
  logic        wbs_in;
  logic        rdwe_in;
  logic        stall;
  logic        req_valid;
  logic        req_ready;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        resp_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd_out;
  logic [31:0] alu_out;
  logic [31:0] ld_out;
  logic        wbs_out;
  logic        rdwe_out;
  logic        mis_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .CLK                       (clk),
    .RST                       (rst),
    .RD_ADDRESS_IN             (rd_in),
    .ALU_OUT_IN                (alu_in),
    .DATA_CACHE_LOAD_IN        (ld_in),
    .DATA_CACHE_STORE_IN       (st_in),
    .DATA_CACHE_STORE_DATA     (sdata_in),
    .WRITE_BACK_MUX_SELECT_IN  (wbs_in),
    .RD_WRITE_ENABLE_IN        (rdwe_in),
    .STALL_MEMORY_STAGE        (stall),
    .MEM_REQ_VALID             (req_valid),
    .MEM_REQ_READY             (req_ready),
    .MEM_WE                    (mem_we),
    .MEM_BYTE_EN               (mem_be),
    .MEM_ADDR                  (mem_addr),
    .MEM_WDATA                 (mem_wdata),
    .MEM_RESP_VALID            (resp_valid),
    .MEM_RDATA                 (mem_rdata),
    .RD_ADDRESS_OUT            (rd_out),
    .ALU_OUT                   (alu_out),
    .LOAD_DATA_OUT             (ld_out),
    .WRITE_BACK_MUX_SELECT_OUT (wbs_out),
    .RD_WRITE_ENABLE_OUT       (rdwe_out),
    .MISALIGNED_ERROR          (mis_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rd"}, rd_out, 0);
    check_eq({tag, "_alu"}, alu_out, 0);
    check_eq({tag, "_ld"}, ld_out, 0);
    check_eq({tag, "_wbs"}, wbs_out, 0);
    check_eq({tag, "_rdwe"}, rdwe_out, 0);
    check_eq({tag, "_mis"}, mis_err, 0);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_req"}, req_valid, 0);
  endtask

  // Called at a falling edge; leaves at the following falling edge after the result is checked.
  task automatic do_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd, input bit wbs,
                       input bit rdwe, input logic [31:0] word, input int rdly, input int rsp);
    bit          is_ld, is_st, mis_e, acc, accepted;
    int          size, off, e_stall, stall_cnt, req_cycles, w;
    logic [31:0] e_addr, e_wdata, e_ld, shifted;
    logic [3:0]  e_be;
    bit          e_rdwe;

    is_ld = (ld >= 1) && (ld <= 5);
    is_st = !is_ld && (st != 0);
    size  = 0;
    if (is_ld)      size = (ld == 1 || ld == 4) ? 1 : (ld == 2 || ld == 5) ? 2 : 4;
    else if (is_st) size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
    off    = int'(addr % 4);
    mis_e  = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
    acc    = (is_ld || is_st) && !mis_e;
    e_addr = addr - 32'(off);

    e_be    = 4'hF;
    e_wdata = sdata;
    if (is_st && size == 1) begin
      e_be    = 4'(1 << off);
      e_wdata = (sdata % 256) * 32'h0101_0101;
    end else if (is_st && size == 2) begin
      e_be    = (off >= 2) ? 4'hC : 4'h3;
      e_wdata = (sdata % 65536) * 32'h0001_0001;
    end

    shifted = word >> (8 * off);
    e_ld    = 0;
    if (acc && is_ld) begin
      case (ld)
        3'd1: begin e_ld = shifted % 256;   if (e_ld >= 128)   e_ld = e_ld + 32'hFFFF_FF00; end
        3'd2: begin e_ld = shifted % 65536; if (e_ld >= 32768) e_ld = e_ld + 32'hFFFF_0000; end
        3'd4: e_ld = shifted % 256;
        3'd5: e_ld = shifted % 65536;
        default: e_ld = shifted;
      endcase
    end
    e_rdwe  = (acc && is_ld) ? rdwe : (acc || mis_e) ? 1'b0 : rdwe;
    e_stall = !acc ? 0 : is_ld ? 2 + rdly + rsp : 2 + rdly;

    ld_in = ld; st_in = st; alu_in = addr; sdata_in = sdata;
    rd_in = rd; wbs_in = wbs; rdwe_in = rdwe;
    #1;
    stall_cnt = 0; req_cycles = 0; w = 0; accepted = 0;
    for (int c = 0; c < 60; c++) begin
      if (!stall) break;
      stall_cnt++;
      if (stall_cnt > 1) check_eq("mis_during_stall", mis_err, 0);
      if (req_valid) begin
        check_eq("req_addr", mem_addr, e_addr);
        check_eq("req_we", mem_we, is_st);
        check_eq("req_be", mem_be, e_be);
        if (is_st) check_eq("req_wdata", mem_wdata, e_wdata);
        req_ready = (req_cycles >= rdly);
        if (req_ready) accepted = 1;
        req_cycles++;
        resp_valid = 1'($urandom % 2);
        mem_rdata  = $urandom;
      end else if (accepted) begin
        req_ready = 0;
        w++;
        resp_valid = (w == rsp);
        mem_rdata  = (w == rsp) ? word : $urandom;
      end else begin
        req_ready  = 1'($urandom % 2);
        resp_valid = 1'($urandom % 2);
        mem_rdata  = $urandom;
      end
      @(negedge clk); #1;
    end
    check_eq("stall_cycles", stall_cnt, e_stall);
    check_eq("req_idle", req_valid, 0);
    req_ready = 0; resp_valid = 0;
    @(posedge clk); #1;
    check_eq("out_rd", rd_out, rd);
    check_eq("out_alu", alu_out, addr);
    check_eq("out_ld", ld_out, e_ld);
    check_eq("out_wbs", wbs_out, wbs);
    check_eq("out_rdwe", rdwe_out, e_rdwe);
    check_eq("out_mis", mis_err, mis_e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; rd_in = 0; alu_in = 0; ld_in = 0; st_in = 0; sdata_in = 0;
    wbs_in = 0; rdwe_in = 0; req_ready = 0; resp_valid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 0;
    @(negedge clk);

    do_op(3'd1, 2'd0, 32'h0000_1003, 32'h0, 5'd3, 1'b1, 1'b1, 32'h80FF_1234, 0, 1);
    do_op(3'd4, 2'd0, 32'h0000_1003, 32'h0, 5'd4, 1'b1, 1'b1, 32'h80FF_1234, 0, 1);
    do_op(3'd0, 2'd2, 32'h0000_2002, 32'h0000_ABCD, 5'd6, 1'b0, 1'b1, 32'h0, 0, 1);
    do_op(3'd3, 2'd0, 32'h0000_3001, 32'h0, 5'd7, 1'b1, 1'b1, 32'h0, 0, 1);
    do_op(3'd0, 2'd0, 32'h0000_0042, 32'h0, 5'd8, 1'b0, 1'b1, 32'h0, 0, 1);
    do_op(3'd3, 2'd0, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 1'b1, 32'hCAFE_F00D, 3, 2);
    do_op(3'd2, 2'd3, 32'h0000_3002, 32'h1, 5'd10, 1'b1, 1'b1, 32'h8001_7FFF, 1, 1);

    // Reset while waiting for a load response; the late response must be dropped.
    ld_in = 3'd3; st_in = 0; alu_in = 32'h0000_4000; rd_in = 5'd11; rdwe_in = 1; wbs_in = 1;
    req_ready = 1;
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("wait_stall", stall, 1);
    check_eq("wait_req", req_valid, 0);
    rst = 1; req_ready = 0;
    ld_in = 0; alu_in = 0; rd_in = 0; rdwe_in = 0; wbs_in = 0;
    @(negedge clk);
    rst = 0; resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_outputs_zero("after_rst");
      @(negedge clk);
    end
    resp_valid = 0;

    do_op(3'd0, 2'd0, 32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b1, 32'h0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] rl;
      logic [1:0] rs;
      rl = 3'($urandom % 8);
      rs = 2'($urandom % 4);
      if ($urandom % 4 == 0) begin rl = 0; rs = 0; end
      do_op(rl, rs, $urandom, $urandom, 5'($urandom), 1'($urandom % 2), 1'($urandom % 2),
            $urandom, int'($urandom % 4), 1 + int'($urandom % 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
